// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU defines for the writeback path: default widths, zero-register
// and zero-word constants, and the round-robin pointer encoding.
package regfile_wb_arbiter_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Register 0 is hard-wired; the zero word is the reset value of the write port.
  localparam int unsigned ZERO_REG_IDX  = 0;
  localparam int unsigned ZERO_WORD_VAL = 0;

  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_ptr_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin selector with an age override for same-register entries.
module wb_rr_arb2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       valid0_i,
  input  logic       valid1_i,
  input  logic       addr_eq_i,
  input  logic       old1_i,
  input  rr_ptr_e    ptr_i,
  output logic [1:0] gnt_o
);

  logic pick1;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    pick1 = 1'b0;
    if (valid0_i && valid1_i) begin
      // Writes to the same register must land in arrival order.
      pick1 = addr_eq_i ? old1_i : (ptr_i == RR_REQ1);
      gnt_o = pick1 ? 2'b10 : 2'b01;
    end else begin
      gnt_o = {valid1_i, valid0_i};
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: two one-entry holding registers feeding one write port.
// Optional read-hazard comparators are built when REGFILE_WB_ARB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic              hz1_o,
  output logic              hz2_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);
  localparam logic [DATA_W-1:0] ZERO_WORD = DATA_W'(ZERO_WORD_VAL);

  logic              hold0_valid_q, hold0_valid_d, hold1_valid_q, hold1_valid_d;
  logic [ADDR_W-1:0] hold0_addr_q, hold1_addr_q;
  logic [DATA_W-1:0] hold0_data_q, hold1_data_q;
  logic              old1_q, old1_d;
  rr_ptr_e           ptr_q, ptr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [1:0]        gnt;
  logic              acc0, acc1, ret0, ret1, addr_eq;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  wb_rr_arb2 u_arb (
    .valid0_i  (hold0_valid_q),
    .valid1_i  (hold1_valid_q),
    .addr_eq_i (addr_eq),
    .old1_i    (old1_q),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt)
  );

  assign addr_eq = (hold0_addr_q == hold1_addr_q) && (hold0_addr_q != ZERO_ADDR);

  // A granted entry frees its slot on the same edge, so it can be refilled at once.
  assign req0_ready_o = rst && (!hold0_valid_q || gnt[0]);
  assign req1_ready_o = rst && (!hold1_valid_q || gnt[1]);
  assign acc0 = req0_valid_i && req0_ready_o;
  assign acc1 = req1_valid_i && req1_ready_o;
  assign ret0 = hold0_valid_q && !gnt[0];
  assign ret1 = hold1_valid_q && !gnt[1];

  assign gnt_addr = gnt[1] ? hold1_addr_q : hold0_addr_q;
  assign gnt_data = gnt[1] ? hold1_data_q : hold0_data_q;

  always_comb begin
    hold0_valid_d = acc0 || ret0;
    hold1_valid_d = acc1 || ret1;
    // Entry 1 is older only if it stays put while entry 0 is new or gone.
    old1_d  = (ret0 && ret1) ? old1_q : (ret1 && !ret0);
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt[0]) begin
      ptr_d = RR_REQ1;
    end else if (gnt[1]) begin
      ptr_d = RR_REQ0;
    end
    if ((gnt != 2'b00) && (gnt_addr != ZERO_ADDR)) begin
      we_d    = 1'b1;
      waddr_d = gnt_addr;
      wdata_d = gnt_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold0_valid_q <= 1'b0;
      hold1_valid_q <= 1'b0;
      old1_q        <= 1'b0;
      ptr_q         <= RR_REQ0;
      we_q          <= 1'b0;
      waddr_q       <= ZERO_ADDR;
      wdata_q       <= ZERO_WORD;
    end else begin
      hold0_valid_q <= hold0_valid_d;
      hold1_valid_q <= hold1_valid_d;
      old1_q        <= old1_d;
      ptr_q         <= ptr_d;
      we_q          <= we_d;
      waddr_q       <= waddr_d;
      wdata_q       <= wdata_d;
    end
  end

  // NOTE: holding payloads carry no reset; they are only observed while their valid flag is set.
  always_ff @(posedge clk) begin
    if (acc0) begin
      hold0_addr_q <= req0_addr_i;
      hold0_data_q <= req0_data_i;
    end
    if (acc1) begin
      hold1_addr_q <= req1_addr_i;
      hold1_data_q <= req1_data_i;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
  // The output stage is excluded: the register file forwards same-cycle writes.
  assign hz1_o = (raddr1_i != ZERO_ADDR) &&
                 ((hold0_valid_q && (hold0_addr_q == raddr1_i)) ||
                  (hold1_valid_q && (hold1_addr_q == raddr1_i)));
  assign hz2_o = (raddr2_i != ZERO_ADDR) &&
                 ((hold0_valid_q && (hold0_addr_q == raddr2_i)) ||
                  (hold1_valid_q && (hold1_addr_q == raddr2_i)));
`else
  logic unused_raddr;
  assign unused_raddr = ^{raddr1_i, raddr2_i};
  assign hz1_o = 1'b0;
  assign hz2_o = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued as stimulus is
// issued and matched against the write port by a negedge monitor.
module tb_regfile_wb_arbiter;

`ifdef REGFILE_WB_ARB_SCOREBOARD_EN
  localparam logic HZ_EN = 1'b1;
`else
  localparam logic HZ_EN = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          start;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_addr = '0, req1_addr = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1 = '0, raddr2 = '0;
  logic        hz1, hz2;

  int checks = 0;
  int failures = 0;

  stim_t       stim0_q[$];
  stim_t       stim1_q[$];
  logic [36:0] exp_q[$];
  logic [36:0] mon_exp;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_addr_i  (req0_addr),
    .req0_data_i  (req0_data),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_addr_i  (req1_addr),
    .req1_data_i  (req1_data),
    .we_o         (we),
    .waddr_o      (waddr),
    .wdata_o      (wdata),
    .raddr1_i     (raddr1),
    .raddr2_i     (raddr2),
    .hz1_o        (hz1),
    .hz2_o        (hz2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every write must be the next one the scoreboard expects.
  always @(negedge clk) begin
    if (rst && we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'({waddr, wdata}), 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", 64'({waddr, wdata}), 64'(mon_exp));
      end
    end
  end

  task automatic expect_write(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic add0(input logic [4:0] a, input logic [31:0] d, input int s);
    stim_t t;
    t.addr = a; t.data = d; t.start = s;
    stim0_q.push_back(t);
  endtask

  task automatic add1(input logic [4:0] a, input logic [31:0] d, input int s);
    stim_t t;
    t.addr = a; t.data = d; t.start = s;
    stim1_q.push_back(t);
  endtask

  // Starts and ends at posedge+#1, like every stimulus task below.
  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    exp_q.delete();
    stim0_q.delete();
    stim1_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready0", 64'(req0_ready), 64'd1);
    check("post_rst_ready1", 64'(req1_ready), 64'd1);
  endtask

  task automatic drain(input string tag);
    repeat (6) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic run_stim(input string tag, input int max_cyc);
    int  cyc;
    bit  a0, a1;
    cyc = 0;
    while ((stim0_q.size() > 0 || stim1_q.size() > 0) && cyc < max_cyc) begin
      req0_valid = (stim0_q.size() > 0) && (stim0_q[0].start <= cyc);
      req1_valid = (stim1_q.size() > 0) && (stim1_q[0].start <= cyc);
      if (req0_valid) begin
        req0_addr = stim0_q[0].addr;
        req0_data = stim0_q[0].data;
      end
      if (req1_valid) begin
        req1_addr = stim1_q[0].addr;
        req1_data = stim1_q[0].data;
      end
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      if (a0) stim0_q.delete(0);
      if (a1) stim1_q.delete(0);
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, "_accepted"}, 64'(stim0_q.size() + stim1_q.size()), 64'd0);
    drain({tag, "_drain"});
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single write: visible two cycles after the request is presented.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hA5A5_A5A5;
    expect_write(5'd3, 32'hA5A5_A5A5);
    @(negedge clk);
    check("lat_ready0_c0", 64'(req0_ready), 64'd1);
    check("lat_we_c0", 64'(we), 64'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("lat_we_c1", 64'(we), 64'd0);
    check("lat_ready0_c1", 64'(req0_ready), 64'd1);
    @(negedge clk);
    check("lat_we_c2", 64'(we), 64'd1);
    check("lat_waddr_c2", 64'(waddr), 64'd3);
    drain("lat_drain");

    // Back-to-back contention from reset: grants alternate 0,1,0,1.
    do_reset();
    add0(5'd1, 32'h10, 0); add0(5'd4, 32'h40, 0);
    add1(5'd2, 32'h20, 0); add1(5'd6, 32'h60, 0);
    expect_write(5'd1, 32'h10); expect_write(5'd2, 32'h20);
    expect_write(5'd4, 32'h40); expect_write(5'd6, 32'h60);
    run_stim("rr", 20);

    // req1 to r7 arrives one cycle ahead of req0 to r7: write order follows arrival.
    do_reset();
    add1(5'd7, 32'h1, 0);
    add0(5'd7, 32'h2, 1);
    expect_write(5'd7, 32'h1); expect_write(5'd7, 32'h2);
    run_stim("order", 20);

    // Pointer favours req1 but both r7 entries arrive together: req0 is older and wins.
    do_reset();
    add0(5'd1, 32'h11, 0); add0(5'd7, 32'h2, 1);
    add1(5'd7, 32'h1, 1);
    expect_write(5'd1, 32'h11); expect_write(5'd7, 32'h2); expect_write(5'd7, 32'h1);
    run_stim("age", 20);

    // Write to register 0 is accepted but never reaches the write port.
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFFFF_FFFF;
    @(negedge clk);
    check("r0_ready0", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("r0_we_c%0d", i + 1), 64'(we), 64'd0);
    end
    drain("r0_drain");

    // Hazard flags follow the held entry and drop once it is written.
    do_reset();
    raddr1 = 5'd9; raddr2 = 5'd0;
    req0_valid = 1'b1; req0_addr = 5'd4; req0_data = 32'h44;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    expect_write(5'd4, 32'h44); expect_write(5'd9, 32'h99);
    @(negedge clk);
    check("hz_ready0", 64'(req0_ready), 64'd1);
    check("hz_ready1", 64'(req1_ready), 64'd1);
    check("hz1_empty", 64'(hz1), 64'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("hz1_held_c1", 64'(hz1), 64'(HZ_EN));
    check("hz2_zero_c1", 64'(hz2), 64'd0);
    @(negedge clk);
    check("hz1_held_c2", 64'(hz1), 64'(HZ_EN));
    check("hz_we_addr4", 64'(waddr), 64'd4);
    @(negedge clk);
    check("hz_we_addr9", 64'({we, waddr}), 64'({1'b1, 5'd9}));
    check("hz1_falls", 64'(hz1), 64'd0);
    check("hz2_falls", 64'(hz2), 64'd0);
    raddr1 = 5'd0;
    drain("hz_drain");

    // Reset mid-operation: the write drops at once and held entries are lost.
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hAA;
    req1_valid = 1'b1; req1_addr = 5'd11; req1_data = 32'hBB;
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_we_before", 64'({we, waddr}), 64'({1'b1, 5'd10}));
    rst = 1'b0;
    #1;
    check("mid_we_async", 64'(we), 64'd0);
    check("mid_ready0", 64'(req0_ready), 64'd0);
    check("mid_ready1", 64'(req1_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_ready0_rel", 64'(req0_ready), 64'd1);
    check("mid_ready1_rel", 64'(req1_ready), 64'd1);
    drain("mid_drain");
    check("mid_we_idle", 64'(we), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width (2^ADDR_W registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid_i/req0_ready_o  in/out  1/1  requester 0 (single-cycle ALU writeback) handshake.
REQ-006 SHALL have ports req0_addr_i/req0_data_i  input  ADDR_W/DATA_W  requester 0 destination register and value.
REQ-007 SHALL have ports req1_valid_i/req1_ready_o, req1_addr_i/req1_data_i  same widths  requester 1 (load, mul/div) handshake and payload.
REQ-008 SHALL have ports we_o/waddr_o/wdata_o  output  1/ADDR_W/DATA_W  register-file write port, driven from flops.
REQ-009 SHALL have ports raddr1_i/raddr2_i  input  ADDR_W  read addresses to hazard-check; hz1_o/hz2_o  output  1  hazard flags (REQ-025).

Function
REQ-010 SHALL accept a request when valid_i and ready_o are both high on a rising edge, into that requester's one-entry holding register.
REQ-011 SHALL drive readyN_o = !holdN_valid | grantN, so a granted entry is refilled in the same cycle.
REQ-012 SHALL be able to accept on both requesters in the same cycle.
REQ-013 SHALL grant at most one valid holding entry per cycle; granted entry is cleared or refilled on that edge.
REQ-014 SHALL register the granted entry into we_o=1, waddr_o, wdata_o on the grant edge (1 cycle from grant to write, minimum 2 cycles from acceptance to we_o).
REQ-015 SHALL drive we_o=0 in any cycle following no grant; waddr_o/wdata_o hold previous values.
REQ-016 SHALL arbitrate round-robin: after granting requester N, requester !N has priority on the next contention.
REQ-017 SHALL, when both entries are valid with equal nonzero addresses, grant the older entry regardless of round-robin pointer; the pointer SHALL still update.
REQ-018 SHALL track age with one flag; simultaneous acceptance makes requester 0 older.
REQ-019 SHALL accept an entry addressed to register 0, consume one grant slot for it, and drive we_o=0 in the resulting cycle.
REQ-020 SHALL grant a lone valid entry immediately, independent of pointer.
REQ-021 SHALL never drop or duplicate an accepted request; order per requester is preserved.

Reset
REQ-022 SHALL, while rst=0, clear both holding valid flags, age flag, we_o, waddr_o (0), wdata_o (0), and set round-robin priority to requester 0.
REQ-023 SHALL discard pending holding entries on reset assertion mid-operation; no write occurs after reset assertion.
REQ-024 SHALL drive both ready_o low while rst=0.

Configuration
REQ-025 With macro REGFILE_WB_ARB_SCOREBOARD_EN defined, hzK_o SHALL be 1 when raddrK_i is nonzero and equals the address of any valid holding entry (combinational); the output stage SHALL NOT raise a hazard, since the register file forwards same-cycle writes.
REQ-026 Without REGFILE_WB_ARB_SCOREBOARD_EN, hz1_o and hz2_o SHALL be tied 0 and the comparators SHALL be absent.

Structure
REQ-027 DATA_W/ADDR_W defaults, the zero-register address and zero-word constants SHALL live in the shared CPU defines package, not in this module.
REQ-028 The two-way round-robin plus age-override selection SHALL be one sub-module, wb_rr_arb2 (inputs: two valid flags, address-equal flag, age, pointer; outputs: one-hot grant).

Verification
REQ-029 After reset release, req0 sends (addr 3, 0xA5A5A5A5) -> we_o=1, waddr_o=3, wdata_o=0xA5A5A5A5 exactly 2 cycles later; ready0 stays 1.
REQ-030 Both requesters valid for 4 back-to-back cycles, distinct addresses -> grants alternate 0,1,0,1; one write per cycle; no loss.
REQ-031 req1 (addr 7, 0x1) accepted one cycle before req0 (addr 7, 0x2), pointer favouring req0 -> writes occur 0x1 then 0x2.
REQ-032 req0 addr 0, data 0xFFFFFFFF -> accepted, we_o stays 0 in the write slot.
REQ-033 With scoreboard enabled, req1 entry addr 9 held by contention, raddr1_i=9, raddr2_i=0 -> hz1_o=1, hz2_o=0; hz1_o falls in the cycle we_o=1 for addr 9.
REQ-034 rst pulsed low while both entries valid -> we_o=0 immediately, no later write of those entries; ready_o=1 after release.
